// File: rtl/nibble_fetch_unit.sv
// -----------------------------------------------------------------------------
// nibble_fetch_unit
//   Instruction sequencer for the Nibble datapath controller. It holds a
//   program counter, reads one instruction word per step from a synchronous
//   instruction memory, and presents op/imm to the controller over a
//   valid/ready handshake. The pc advances, sequentially or by jump, only
//   when the controller accepts the instruction.
//
// Parameters
//   ADDR_W    program counter / imem address width
//   MEM_LAT   imem read latency in cycles (>= 1)
//   HALT_WORD instruction word that stops sequencing
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   start           begin or resume sequencing from IDLE or HALTED
//   halt_req        stop at the next instruction boundary
//   imem_addr       instruction address (equals pc, combinational)
//   imem_rdata      instruction word {op[2:0], imm[3:0], spare}
//   op_out, imm_out registered opcode / immediate
//   op_valid        op_out/imm_out valid; held until op_ready
//   op_ready        controller accepts the instruction
//   jump_en/addr    sampled at handshake: load pc from jump_addr
//   pc              current program counter
//   running         high in FETCH/WAIT/PRESENT
//   halted          high in HALTED
// -----------------------------------------------------------------------------
module nibble_fetch_unit #(
  parameter int          ADDR_W    = 6,
  parameter int          MEM_LAT   = 1,
  parameter logic [7:0]  HALT_WORD = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [2:0]        op_out,
  output logic [3:0]        imm_out,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_HALTED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             halt_pend;
  logic             word_is_halt;  // the presented word is HALT_WORD

  assign imem_addr = pc;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  // NOTE: asynchronous reset aborts any in-flight fetch; nothing captured
  // by a pending read survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      op_out       <= '0;
      imm_out      <= '0;
      op_valid     <= 1'b0;
      running      <= 1'b0;
      halted       <= 1'b0;
      halt_pend    <= 1'b0;
      wait_cnt     <= '0;
      word_is_halt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            running <= 1'b1;
          end
        end

        S_FETCH: begin
          if (halt_req) halt_pend <= 1'b1;
          wait_cnt <= CNT_LOAD;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (halt_req) halt_pend <= 1'b1;
          if (wait_cnt == '0) begin
            op_out       <= imem_rdata[7:5];
            imm_out      <= imem_rdata[4:1];
            word_is_halt <= (imem_rdata == HALT_WORD);
            op_valid     <= 1'b1;
            state        <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_PRESENT: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            if (word_is_halt) begin
              // Halt instruction: pc stays on it so a resume refetches it.
              state     <= S_HALTED;
              running   <= 1'b0;
              halted    <= 1'b1;
              halt_pend <= 1'b0;
            end else begin
              pc <= jump_en ? jump_addr : pc + ADDR_W'(1);
              if (halt_pend || halt_req) begin
                state     <= S_HALTED;
                running   <= 1'b0;
                halted    <= 1'b1;
                halt_pend <= 1'b0;
              end else begin
                state <= S_FETCH;
              end
            end
          end else if (halt_req) begin
            halt_pend <= 1'b1;
          end
        end

        S_HALTED: begin
          // start wins over a simultaneous halt_req, which is kept pending.
          if (start) begin
            state   <= S_FETCH;
            running <= 1'b1;
            halted  <= 1'b0;
            if (halt_req) halt_pend <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
